snake_motion_engine: RTL and testbench
======================================

Name: snake_motion_engine

Overview:
- Consumer end of the key-control interface: takes one-hot game state, one-hot move direction and the speed select, and advances the snake on a grid.
- Keeps the head and body segment coordinates and grows on apple capture.
- Detects wall and self collision and returns `game_over` to the key controller.
- Provides a registered per-cell query (head/body hit) for the VGA renderer.

Parameters:
- GRID_W, 40, grid columns (x range 0..GRID_W-1)
- GRID_H, 30, grid rows (y range 0..GRID_H-1)
- MAX_LEN, 16, maximum segment count including the head
- INIT_LEN, 3, length after reset or START
- START_X, 10, initial head column
- START_Y, 15, initial head row
- STEP_SLOW, 25_000_000, clk cycles per step when `speed_m`=1
- STEP_FAST, 12_500_000, clk cycles per step when `speed_m`=0

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- state_m  in  4  game state, one-hot: START=0001, SPEED=0010, PLAY=0100, END=1000
- move_d  in  4  direction, one-hot: RIGHT=0001, LEFT=0010, DOWN=0100, UP=1000
- speed_m  in  1  1=slow, 0=fast
- apple_x  in  6  apple column
- apple_y  in  5  apple row
- apple_valid  in  1  apple coordinates are meaningful
- pix_x  in  6  query column
- pix_y  in  5  query row
- game_over  out  1  collision flag, level
- apple_eaten  out  1  one-cycle pulse on capture
- head_x  out  6  current head column
- head_y  out  5  current head row
- length  out  5  current segment count
- is_head  out  1  query hit on head, 1-cycle latency
- is_body  out  1  query hit on a non-head live segment, 1-cycle latency

Behaviour:
- Reset is asynchronous (`rst_n` low).
  - Segments: seg[i] = (START_X-i, START_Y) for all i.
  - `length`=INIT_LEN; `game_over`=0, `apple_eaten`=0, `is_head`=0, `is_body`=0; step counter=0.
- START: every cycle, re-initialise all state to reset values, except that `is_head`/`is_body` keep tracking queries.
- SPEED: segments and counter hold. Counter is forced to 0.
- PLAY: step counter increments each cycle.
  - When counter reaches period-1, where period = STEP_SLOW if `speed_m`=1 else STEP_FAST (sampled that cycle), assert internal step and clear the counter.
- END, or any non-one-hot `state_m`: everything holds; `game_over` holds.
- On a step, the next head is seg[0] moved by `move_d`: RIGHT x+1, LEFT x-1, DOWN y+1, UP y-1.
  - A non-one-hot `move_d` means no move that step; the counter still restarts.
- Wall collision: head at x=0 moving LEFT, x=GRID_W-1 moving RIGHT, y=0 moving UP, or y=GRID_H-1 moving DOWN.
  - No coordinate wraps or underflows.
- grow = `apple_valid` and next head == (`apple_x`, `apple_y`).
- Self collision: next head equals any live seg[i], compared over:
  - 1 <= i <= length-2 when not growing (the tail vacates);
  - 1 <= i <= length-1 when growing.
- Any collision:
  - `game_over` <= 1 on the next edge;
  - segments, `length` and `apple_eaten` unchanged;
  - counter stops advancing until the state leaves PLAY.
- Legal step:
  - seg[i] <= seg[i-1] for i >= 1, seg[0] <= next head, all in one cycle.
  - If grow and `length` < MAX_LEN: `length` += 1; the new tail is the old tail position, retained by the shift.
  - If grow: `apple_eaten`=1 for exactly the following cycle, including at MAX_LEN with no growth.
- `game_over` clears only when `state_m`=START. It is held through END and SPEED.
- Collision and eat in the same step: collision wins, no `apple_eaten`.
- `head_x`/`head_y` are registered, equal to seg[0].
- Query, registered with 1-cycle latency:
  - `is_head` = (`pix_x`, `pix_y`) == seg[0];
  - `is_body` = match on any seg[i] with 1 <= i < `length`.
  - Segments at index >= `length` never produce a hit.
- Reset asserted mid-step aborts the step; there is no partial shift.

Decomposition:
- Package snake_pkg holds:
  - state encodings ST_START/ST_SPEED/ST_PLAY/ST_END;
  - direction encodings DIR_RIGHT/LEFT/DOWN/UP;
  - coordinate widths X_W=6, Y_W=5;
  - a typedef for a (x,y) grid point.
- One sub-module, snake_step_timer:
  - inputs: clk, rst_n, enable, clear, speed_m, parameters STEP_SLOW/STEP_FAST;
  - output: one-cycle step pulse.
- Collision, shift register and query logic stay in the top module.

Test Plan:
- All tests use STEP_SLOW=8, STEP_FAST=4.
- Test 1: reset, then START for 2 cycles.
  - `head`=(10,15), `length`=3.
  - Query (9,15) gives `is_body`=1; query (7,15) gives 0; `game_over`=0.
- Test 2: PLAY with `speed_m`=1, `move_d`=RIGHT.
  - First step at cycle 8 after PLAY entry: head (11,15).
  - Step at cycle 16: head (12,15).
  - Switch `speed_m` to 0: subsequent steps every 4 cycles.
- Test 3: apple at (11,15), `apple_valid`=1, first step.
  - `apple_eaten` pulses for 1 cycle; `length`=4.
  - Query (8,15) gives `is_body`=1 (old tail retained).
- Test 4: walk RIGHT until `head_x`=39, then one more step.
  - `game_over`=1, `head_x` stays 39.
  - Set `state_m`=END: holds. Set `state_m`=START: `game_over`=0, head (10,15).
- Test 5: grow to length 5, then UP, LEFT, DOWN into the body.
  - `game_over`=1 on the colliding step; segments unchanged.
  - At length 4, the same loop into the vacating tail is legal (no `game_over`).
- Test 6: reach `length`=MAX_LEN=16, then eat once more.
  - `apple_eaten` pulses; `length` stays 16.
  - Also: drop `rst_n` mid-count; all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings and grid point type for the snake motion engine.
package snake_pkg;

  localparam int unsigned X_W = 6;
  localparam int unsigned Y_W = 5;

  localparam logic [3:0] ST_START = 4'b0001;
  localparam logic [3:0] ST_SPEED = 4'b0010;
  localparam logic [3:0] ST_PLAY  = 4'b0100;
  localparam logic [3:0] ST_END   = 4'b1000;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b1000;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;

endpackage

// File: rtl/snake_step_timer.sv
// Step-rate divider: emits a one-cycle step pulse every STEP_SLOW or STEP_FAST enabled cycles.
module snake_step_timer #(
  parameter int unsigned STEP_SLOW = 25_000_000,
  parameter int unsigned STEP_FAST = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic speed_m,
  output logic step
);

  localparam int unsigned MaxPeriod = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
  localparam int unsigned CntW      = (MaxPeriod > 2) ? $clog2(MaxPeriod) : 1;
  localparam logic [CntW-1:0] SlowLast = CntW'(STEP_SLOW - 1);
  localparam logic [CntW-1:0] FastLast = CntW'(STEP_FAST - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    // >= so a slow-to-fast switch past the fast limit still fires instead of wrapping
    step  = enable && (cnt_q >= (speed_m ? SlowLast : FastLast));
    cnt_d = cnt_q;
    if (clear || step) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_motion_engine.sv
// Snake segment shift register with wall/self collision, apple growth and a registered
// per-cell head/body query for the renderer.
module snake_motion_engine
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned INIT_LEN  = 3,
  parameter int unsigned START_X   = 10,
  parameter int unsigned START_Y   = 15,
  parameter int unsigned STEP_SLOW = 25_000_000,
  parameter int unsigned STEP_FAST = 12_500_000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     state_m,
  input  logic [3:0]     move_d,
  input  logic           speed_m,
  input  logic [X_W-1:0] apple_x,
  input  logic [Y_W-1:0] apple_y,
  input  logic           apple_valid,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  output logic           game_over,
  output logic           apple_eaten,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [4:0]     length,
  output logic           is_head,
  output logic           is_body
);

  localparam logic [4:0] InitLen = 5'(INIT_LEN);
  localparam logic [4:0] MaxLen  = 5'(MAX_LEN);

  // Unused slots past the initial length may hold wrapped columns; they are never live.
  function automatic point_t init_seg(int i);
    point_t p;
    p.x = X_W'(START_X - i);
    p.y = Y_W'(START_Y);
    return p;
  endfunction

  point_t     seg_q [MAX_LEN];
  point_t     seg_d [MAX_LEN];
  logic [4:0] len_q, len_d;
  logic       go_q, go_d, eaten_q, eaten_d;
  logic       is_head_q, is_head_d, is_body_q, is_body_d;

  logic   st_start, st_speed, st_play, step;
  logic   move_ok, wall, grow, self_hit;
  point_t head, nxt, apple, pix;

  assign st_start = (state_m == ST_START);
  assign st_speed = (state_m == ST_SPEED);
  assign st_play  = (state_m == ST_PLAY);
  assign apple    = {apple_x, apple_y};
  assign pix      = {pix_x, pix_y};

  snake_step_timer #(
    .STEP_SLOW(STEP_SLOW),
    .STEP_FAST(STEP_FAST)
  ) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (st_play && !go_q),
    .clear  (st_start || st_speed),
    .speed_m(speed_m),
    .step   (step)
  );

  always_comb begin
    head    = seg_q[0];
    nxt     = head;
    move_ok = 1'b1;
    wall    = 1'b0;
    case (move_d)
      DIR_RIGHT: if (head.x == X_W'(GRID_W - 1)) wall = 1'b1; else nxt.x = head.x + X_W'(1);
      DIR_LEFT:  if (head.x == '0)               wall = 1'b1; else nxt.x = head.x - X_W'(1);
      DIR_DOWN:  if (head.y == Y_W'(GRID_H - 1)) wall = 1'b1; else nxt.y = head.y + Y_W'(1);
      DIR_UP:    if (head.y == '0)               wall = 1'b1; else nxt.y = head.y - Y_W'(1);
      default:   move_ok = 1'b0;
    endcase
    grow = apple_valid && (nxt == apple);
    // The tail only counts as an obstacle when growth keeps it in place
    self_hit = 1'b0;
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if ((seg_q[i] == nxt) && (i < int'(len_q) - (grow ? 0 : 1))) self_hit = 1'b1;
    end
  end

  always_comb begin
    seg_d   = seg_q;
    len_d   = len_q;
    go_d    = go_q;
    eaten_d = 1'b0;
    if (st_start) begin
      for (int i = 0; i < int'(MAX_LEN); i++) seg_d[i] = init_seg(i);
      len_d = InitLen;
      go_d  = 1'b0;
    end else if (step && move_ok) begin
      if (wall || self_hit) begin
        go_d = 1'b1;
      end else begin
        seg_d[0] = nxt;
        for (int i = 1; i < int'(MAX_LEN); i++) seg_d[i] = seg_q[i-1];
        if (grow && (len_q < MaxLen)) len_d = len_q + 5'd1;
        eaten_d = grow;
      end
    end
    is_head_d = (pix == seg_q[0]);
    is_body_d = 1'b0;
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if ((i < int'(len_q)) && (seg_q[i] == pix)) is_body_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_LEN); i++) seg_q[i] <= init_seg(i);
      len_q     <= InitLen;
      go_q      <= 1'b0;
      eaten_q   <= 1'b0;
      is_head_q <= 1'b0;
      is_body_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      len_q     <= len_d;
      go_q      <= go_d;
      eaten_q   <= eaten_d;
      is_head_q <= is_head_d;
      is_body_q <= is_body_d;
    end
  end

  assign game_over   = go_q;
  assign apple_eaten = eaten_q;
  assign head_x      = seg_q[0].x;
  assign head_y      = seg_q[0].y;
  assign length      = len_q;
  assign is_head     = is_head_q;
  assign is_body     = is_body_q;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Bench for snake_motion_engine: queue-based snake model checked every cycle, plus directed
// literal checks on the scenarios of interest.
module tb_snake_motion_engine;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state_m, move_d;
  logic       speed_m, apple_valid;
  logic [5:0] apple_x, pix_x, head_x;
  logic [4:0] apple_y, pix_y, head_y, length;
  logic       game_over, apple_eaten, is_head, is_body;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snake_motion_engine #(
    .STEP_SLOW(8),
    .STEP_FAST(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state_m    (state_m),
    .move_d     (move_d),
    .speed_m    (speed_m),
    .apple_x    (apple_x),
    .apple_y    (apple_y),
    .apple_valid(apple_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .game_over  (game_over),
    .apple_eaten(apple_eaten),
    .head_x     (head_x),
    .head_y     (head_y),
    .length     (length),
    .is_head    (is_head),
    .is_body    (is_body)
  );

  function automatic void chk(string name, logic [31:0] act, int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: snake as a queue of cells, head at index 0, only live cells stored.
  int bx[$];
  int by[$];
  int m_go, m_eaten, m_ih, m_ib, m_cnt;
  bit model_on = 1'b0;

  function automatic void model_reset();
    bx.delete();
    by.delete();
    for (int i = 0; i < 3; i++) begin
      bx.push_back(10 - i);
      by.push_back(15);
    end
    m_go    = 0;
    m_eaten = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_step();
    int  dx = 0;
    int  dy = 0;
    int  nx, ny, n;
    bit  wall, grow, hit;
    case (move_d)
      4'b0001: dx = 1;
      4'b0010: dx = -1;
      4'b0100: dy = 1;
      4'b1000: dy = -1;
      default: return;
    endcase
    nx   = bx[0] + dx;
    ny   = by[0] + dy;
    wall = (nx < 0) || (nx >= 40) || (ny < 0) || (ny >= 30);
    grow = apple_valid && (nx == int'(apple_x)) && (ny == int'(apple_y));
    n    = grow ? bx.size() : bx.size() - 1;
    hit  = 1'b0;
    for (int i = 1; i < n; i++) if (bx[i] == nx && by[i] == ny) hit = 1'b1;
    if (wall || hit) begin
      m_go = 1;
      return;
    end
    bx.push_front(nx);
    by.push_front(ny);
    if (!(grow && bx.size() <= 16)) begin
      void'(bx.pop_back());
      void'(by.pop_back());
    end
    m_eaten = grow ? 1 : 0;
  endfunction

  function automatic void model_edge();
    int px = int'(pix_x);
    int py = int'(pix_y);
    int period;
    m_ih = (px == bx[0] && py == by[0]) ? 1 : 0;
    m_ib = 0;
    for (int i = 1; i < bx.size(); i++) if (bx[i] == px && by[i] == py) m_ib = 1;
    m_eaten = 0;
    case (state_m)
      4'b0001: model_reset();
      4'b0010: m_cnt = 0;
      4'b0100: begin
        if (m_go == 0) begin
          period = speed_m ? 8 : 4;
          if (m_cnt >= period - 1) begin
            m_cnt = 0;
            model_step();
          end else begin
            m_cnt++;
          end
        end
      end
      default: ;
    endcase
  endfunction

  initial begin
    model_reset();
    m_ih = 0;
    m_ib = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        m_ih = 0;
        m_ib = 0;
      end else begin
        model_edge();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("m_head_x", head_x, bx[0]);
        chk("m_head_y", head_y, by[0]);
        chk("m_length", length, bx.size());
        chk("m_game_over", game_over, m_go);
        chk("m_apple_eaten", apple_eaten, m_eaten);
        chk("m_is_head", is_head, m_ih);
        chk("m_is_body", is_body, m_ib);
      end
    end
  end

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pix(int x, int y);
    pix_x = 6'(x);
    pix_y = 5'(y);
  endtask

  task automatic set_apple(int x, int y, logic v);
    apple_x     = 6'(x);
    apple_y     = 5'(y);
    apple_valid = v;
  endtask

  initial begin
    int k;
    state_m = ST_START;
    move_d  = DIR_RIGHT;
    speed_m = 1'b1;
    set_apple(0, 0, 1'b0);
    set_pix(0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_on = 1'b1;
    wait_neg(2);
    rst_n = 1'b1;

    // Reset / START state and query
    wait_neg(2);
    chk("t1_head_x", head_x, 10);
    chk("t1_head_y", head_y, 15);
    chk("t1_length", length, 3);
    chk("t1_game_over", game_over, 0);
    set_pix(9, 15);
    wait_neg(1);
    chk("t1_body_9_15", is_body, 1);
    set_pix(7, 15);
    wait_neg(1);
    chk("t1_body_7_15", is_body, 0);
    set_pix(10, 15);
    wait_neg(1);
    chk("t1_head_10_15", is_head, 1);
    chk("t1_nobody_10_15", is_body, 0);

    // Slow then fast stepping to the right
    state_m = ST_PLAY;
    wait_neg(7);
    chk("t2_before_step", head_x, 10);
    wait_neg(1);
    chk("t2_step1", head_x, 11);
    wait_neg(8);
    chk("t2_step2", head_x, 12);
    speed_m = 1'b0;
    wait_neg(3);
    chk("t2_fast_wait", head_x, 12);
    wait_neg(1);
    chk("t2_fast_step", head_x, 13);

    // Apple capture on the first step
    state_m = ST_START;
    wait_neg(1);
    chk("t3_restart", head_x, 10);
    state_m = ST_PLAY;
    set_apple(11, 15, 1'b1);
    wait_neg(4);
    chk("t3_eaten", apple_eaten, 1);
    chk("t3_len", length, 4);
    chk("t3_head", head_x, 11);
    state_m = ST_SPEED;
    set_apple(0, 0, 1'b0);
    set_pix(8, 15);
    wait_neg(1);
    chk("t3_eaten_clr", apple_eaten, 0);
    chk("t3_old_tail", is_body, 1);
    wait_neg(2);
    chk("t3_speed_hold", head_x, 11);

    // Walk into the right wall
    state_m = ST_PLAY;
    k = 0;
    while (head_x != 6'd39 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t4_reach_39", head_x, 39);
    chk("t4_no_go_yet", game_over, 0);
    wait_neg(4);
    chk("t4_wall_go", game_over, 1);
    chk("t4_wall_x", head_x, 39);
    state_m = ST_END;
    wait_neg(3);
    chk("t4_end_go", game_over, 1);
    chk("t4_end_x", head_x, 39);
    state_m = ST_START;
    wait_neg(1);
    chk("t4_start_go", game_over, 0);
    chk("t4_start_x", head_x, 10);
    chk("t4_start_y", head_y, 15);

    // Length 5 loop into the body collides
    state_m = ST_PLAY;
    move_d  = DIR_RIGHT;
    set_apple(11, 15, 1'b1);
    wait_neg(4);
    chk("t5_len4", length, 4);
    set_apple(12, 15, 1'b1);
    wait_neg(4);
    chk("t5_len5", length, 5);
    set_apple(0, 0, 1'b0);
    move_d = DIR_UP;
    wait_neg(4);
    chk("t5_up_y", head_y, 14);
    move_d = DIR_LEFT;
    wait_neg(4);
    chk("t5_left_x", head_x, 11);
    move_d = DIR_DOWN;
    set_pix(12, 15);
    wait_neg(4);
    chk("t5_self_go", game_over, 1);
    chk("t5_frozen_x", head_x, 11);
    chk("t5_frozen_y", head_y, 14);
    chk("t5_frozen_len", length, 5);
    chk("t5_frozen_body", is_body, 1);

    // Length 4 loop into the vacating tail is legal
    state_m = ST_START;
    wait_neg(1);
    state_m = ST_PLAY;
    move_d  = DIR_RIGHT;
    set_apple(11, 15, 1'b1);
    wait_neg(4);
    set_apple(0, 0, 1'b0);
    move_d = DIR_UP;
    wait_neg(4);
    move_d = DIR_LEFT;
    wait_neg(4);
    move_d = DIR_DOWN;
    wait_neg(4);
    chk("t5b_no_go", game_over, 0);
    chk("t5b_head_x", head_x, 10);
    chk("t5b_head_y", head_y, 15);

    // Grow to MAX_LEN and eat once more
    state_m = ST_START;
    wait_neg(1);
    state_m = ST_PLAY;
    move_d  = DIR_RIGHT;
    for (int i = 0; i < 14; i++) begin
      set_apple(11 + i, 15, 1'b1);
      wait_neg(4);
      if (i == 12) chk("t6_len_max", length, 16);
      if (i == 13) begin
        chk("t6_eat_at_max", apple_eaten, 1);
        chk("t6_len_stays", length, 16);
        chk("t6_head", head_x, 24);
      end
    end
    set_apple(0, 0, 1'b0);

    // Asynchronous reset mid-count
    wait_neg(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_x", head_x, 10);
    chk("t6_rst_y", head_y, 15);
    chk("t6_rst_len", length, 3);
    chk("t6_rst_go", game_over, 0);
    chk("t6_rst_eaten", apple_eaten, 0);
    chk("t6_rst_ih", is_head, 0);
    chk("t6_rst_ib", is_body, 0);
    state_m = ST_START;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
    state_m = ST_PLAY;
    wait_neg(3);
    chk("t6_post_wait", head_x, 10);
    wait_neg(1);
    chk("t6_post_step", head_x, 11);

    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
